load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory port; drives MemRead/MemWrite, word index and write data, and consumes the combinational read data.
- Accepts one byte/half/word load or store from the core over a valid/ready request, performs the access, and returns one response.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- Loads are sign- or zero-extended. Misaligned or out-of-range requests are flagged with an error and never touch memory.

Parameters:
- DEPTH, 64: number of 32-bit words in data memory; byte addresses at or above 4*DEPTH are out of range.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  LSU can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends when 1; ignored for stores
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  qualified by rsp_valid: misaligned, out of range, or illegal size
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- mem_address  output  32  word index (req_addr >> 2), zero-extended
- mem_wdata  output  32  full word written
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; rsp_valid, rsp_err, MemRead, MemWrite = 0; rsp_rdata, mem_address, mem_wdata = 0; all internal latches cleared.
- Reset mid-operation: the access is abandoned and MemWrite drops immediately. No response is issued for the abandoned request.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. All request fields are latched at that edge. Call the accepting cycle C.
- Error check at acceptance: error when
  - req_size=11, or
  - size=01 and addr[0]≠0, or
  - size=10 and addr[1:0]≠0, or
  - addr[31:2] ≥ DEPTH.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE → next state by request type:
  - error → RESP
  - load → LOAD
  - word store → STORE
  - byte/half store → RMW_RD
- LOAD: MemRead=1, mem_address = word index. mem_rdata is captured at the end of the cycle → RESP.
- STORE: MemWrite=1, mem_wdata = latched wdata → RESP.
- RMW_RD: MemRead=1, mem_rdata is captured → RMW_WR.
- RMW_WR: MemWrite=1, mem_wdata = captured word with the target lane(s) replaced → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE.
- Outside their states: MemRead and MemWrite are 0, and MemRead and MemWrite are never high together.
- mem_address holds the word index during memory states and is 0 otherwise.
- Response latency: error at C+1; load and word store at C+2; sub-word store at C+3.
- Throughput: the next request is accepted in the cycle after RESP. Back-to-back requests see no stale data.
- Lane rules are little-endian; byte lane = addr[1:0], half lane = addr[1].
  - Store byte: wdata[7:0] goes to byte lane addr[1:0].
  - Store half: wdata[15:0] goes to bits [16*addr[1] +: 16].
  - Load: the selected lane is extracted to the LSB and sign-extended from bit 7/15, or zero-extended when req_unsigned=1. Words pass through unchanged.
- Error response: rsp_err=1, rsp_rdata=0, no MemRead/MemWrite pulse.
- req_valid asserted outside IDLE is ignored; it is not queued.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - function for the out-of-range check
- Sub-module lsu_lane_align (combinational):
  - load extract/extend: addr[1:0], size, unsigned, word → data
  - store merge: addr[1:0], size, old word, wdata → new word
- The top level holds the FSM and the latches.

Test Plan:
- Word store then load:
  - store 0xDEADBEEF @0x10 → MemWrite high one cycle with mem_address=4; rsp at C+2, err=0.
  - load word @0x10 → rsp_rdata=0xDEADBEEF at C+2.
- Byte RMW: memory word 1 = 0x11223344; store byte 0xAA @0x06 → MemRead cycle, then MemWrite mem_wdata=0x11AA3344; rsp at C+3.
- Sign/zero extension: word 0 = 0x80F0017F.
  - load byte signed @0x0 → 0x0000007F
  - load byte signed @0x2 → 0xFFFFFFF0
  - load half unsigned @0x2 → 0x000080F0
  - load half signed @0x2 → 0xFFFF80F0
- Errors, no memory enable asserted, rsp_err=1 at C+1, rdata=0:
  - load half @0x3
  - store word @0x102 (misaligned)
  - load word @0x100 (out of range, DEPTH=64)
  - size=11
- Reset mid-RMW: assert reset during RMW_WR → MemWrite drops asynchronously, no rsp_valid, req_ready=1 after release; the memory word is unchanged.
- Back-to-back: req_valid held high with two loads → second accepted the cycle after the first RESP; req_ready low in all non-IDLE states.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - size encodings for byte/half/word requests
//   - FSM state enum
//   - address range and alignment helpers used at request acceptance
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // Word index at or beyond the memory depth is out of range.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] depth);
    return ({2'b00, addr[31:2]} >= depth);
  endfunction

  // Halves need bit 0 clear, words need bits [1:0] clear; bytes never misalign.
  function automatic logic addr_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering.
//   i_lane     : byte offset within the word (addr[1:0])
//   i_size     : access size encoding
//   i_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   i_rword    : word read from memory (load path)
//   o_ldata    : selected lane moved to the LSBs and extended
//   i_oword    : existing memory word (store merge path)
//   i_wdata    : right-justified store data
//   o_sword    : i_oword with the target lane(s) replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  output logic [31:0] o_ldata,
  input  logic [31:0] i_oword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_sword
);

  logic [4:0]  w_bsel;
  logic [4:0]  w_hsel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsel = {i_lane, 3'b000};
  assign w_hsel = {i_lane[1], 4'b0000};
  assign w_byte = i_rword[w_bsel +: 8];
  assign w_half = i_rword[w_hsel +: 16];

  always_comb begin
    o_ldata = i_rword;
    case (i_size)
      SZ_BYTE: o_ldata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ldata = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_ldata = i_rword;
    endcase
  end

  always_comb begin
    o_sword = i_oword;
    case (i_size)
      SZ_BYTE: o_sword[w_bsel +: 8]  = i_wdata[7:0];
      SZ_HALF: o_sword[w_hsel +: 16] = i_wdata[15:0];
      default: o_sword = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a
// word-addressed data memory with combinational read data.
//   clk, reset           : clock, async active-high reset
//   req_*                : core request (valid/ready), fields latched on accept
//   rsp_valid/rdata/err  : one-cycle response strobe
//   MemRead/MemWrite     : memory enables, only in memory states
//   mem_address          : word index during memory states, else 0
//   mem_wdata            : full word written (merged for sub-word stores)
//   mem_rdata            : combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state, w_next;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rword;

  logic        w_accept, w_err;
  logic [31:0] w_ldata, w_sword, w_widx;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_err    = (req_size == SZ_ILL)
                 || addr_misaligned(req_size, req_addr[1:0])
                 || addr_out_of_range(req_addr, 32'(DEPTH));
  assign w_widx   = {2'b00, r_addr[31:2]};

  lsu_lane_align u_align (
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_rword    (r_rword),
    .o_ldata    (w_ldata),
    .i_oword    (r_rword),
    .i_wdata    (r_wdata),
    .o_sword    (w_sword)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rword <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_err   <= w_err;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Read data is combinational, so it is valid at the end of the read cycle.
      if (r_state == ST_LOAD || r_state == ST_RMW_RD)
        r_rword <= mem_rdata;
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_err)                   w_next = ST_RESP;
          else if (!req_we)            w_next = ST_LOAD;
          else if (req_size == SZ_WORD) w_next = ST_STORE;
          else                         w_next = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        MemRead     = 1'b1;
        mem_address = w_widx;
        w_next      = ST_RESP;
      end
      ST_STORE: begin
        MemWrite    = 1'b1;
        mem_address = w_widx;
        mem_wdata   = r_wdata;
        w_next      = ST_RESP;
      end
      ST_RMW_RD: begin
        MemRead     = 1'b1;
        mem_address = w_widx;
        w_next      = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        MemWrite    = 1'b1;
        mem_address = w_widx;
        mem_wdata   = w_sword;
        w_next      = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        // Only successful loads return data; stores and errors return 0.
        if (!r_err && !r_we) rsp_rdata = w_ldata;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, MemRead, MemWrite;
  logic [31:0] rsp_rdata, mem_address, mem_wdata, mem_rdata;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device: combinational read, write on rising edge.
  logic [31:0] mem [DEPTH];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  assign mem_rdata = mem[mem_address[5:0]];
  always @(posedge clk)
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (MemWrite) mem[mem_address[5:0]] <= mem_wdata;

  // Reference model: byte-addressed memory image.
  logic [7:0] rmem [4*DEPTH];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 6'(idx); pre_data = w;
    for (int i = 0; i < 4; i++) rmem[4*idx+i] = w[8*i +: 8];
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {rmem[4*idx+3], rmem[4*idx+2], rmem[4*idx+1], rmem[4*idx]};
  endfunction

  task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((addr % nb) != 0) || (addr >= 32'(4*DEPTH));
    rd = '0; v = '0;
    if (er) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (!we) begin
      for (int i = 0; i < nb; i++) v = v | (32'(rmem[addr+i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1])
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      rd = v; lat = 2; nrd = 1; nwr = 0;
    end else begin
      for (int i = 0; i < nb; i++) rmem[addr+i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 3; nrd = (nb == 4) ? 0 : 1; nwr = 1;
    end
  endtask

  // Issue one request from IDLE and observe the DUT until its response.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int nrd, output int nwr, output logic [31:0] maddr,
                     output logic [31:0] mwd, output int bad);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    bad = req_ready ? 0 : 1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = -1; rd = 'x; er = 1'bx; nrd = 0; nwr = 0; maddr = '0; mwd = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead && MemWrite) bad++;
      if (req_ready) bad++;
      if (MemRead) begin nrd++; maddr = mem_address; end
      if (MemWrite) begin nwr++; maddr = mem_address; mwd = mem_wdata; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
    end
  endtask

  // Run one request and compare against the model (and optional fixed expectations).
  task automatic run(input string nm, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic fixed, input logic [31:0] f_rd, input logic f_er,
                     input int f_lat);
    int lat, nrd, nwr, bad, e_lat, e_nrd, e_nwr;
    logic [31:0] rd, maddr, mwd, e_rd;
    logic er, e_er;
    ref_op(we, sz, uns, addr, wdata, e_rd, e_er, e_lat, e_nrd, e_nwr);
    if (fixed) begin e_rd = f_rd; e_er = f_er; e_lat = f_lat; end
    txn(we, sz, uns, addr, wdata, lat, rd, er, nrd, nwr, maddr, mwd, bad);
    chk({nm, ".lat"},   32'(lat), 32'(e_lat));
    chk({nm, ".rdata"}, rd, e_rd);
    chk({nm, ".err"},   {31'd0, er}, {31'd0, e_er});
    chk({nm, ".nrd"},   32'(nrd), 32'(e_nrd));
    chk({nm, ".nwr"},   32'(nwr), 32'(e_nwr));
    chk({nm, ".busy"},  32'(bad), 32'd0);
    if (!e_er) chk({nm, ".maddr"}, maddr, addr >> 2);
    if (!e_er && we) chk({nm, ".mwdata"}, mwd, ref_word(int'(addr >> 2)));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vec_t v;
    int lat, nrd, nwr, bad, k1, acc2, nrsp, busy_hi;
    logic [31:0] rd, maddr, mwd, e_a, e_b, r1, r2, rtmp;
    logic er, etmp;
    int t1, t2, t3;
    int rk [2];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst.memrd", {31'd0, MemRead}, 32'd0);
    chk("rst.memwr", {31'd0, MemWrite}, 32'd0);
    chk("rst.maddr", mem_address, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) preload(i, 32'd0);
    preload(0, 32'h80F0017F);
    preload(1, 32'h11223344);

    //        we    sz     uns   addr         wdata          rd             er    lat
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h06,  32'h123456AA, 32'h0,         1'b0, 3});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h04,  32'h0,        32'h11AA3344,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h00,  32'h0,        32'h0000007F,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h02,  32'h0,        32'hFFFFFFF0,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h02,  32'h0,        32'h000080F0,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h02,  32'h0,        32'hFFFF80F0,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h03,  32'h0,        32'h0,         1'b1, 1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h102, 32'h5555AAAA, 32'h0,         1'b1, 1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1, 1});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        32'h0,         1'b1, 1});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12,  32'hCAFE5678, 32'h0,         1'b0, 3});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h5678BEEF,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h00000056,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFFBE,  1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h0,         1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'hFF,  32'h000000C3, 32'h0,         1'b0, 3});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'hC3000000,  1'b0, 2});

    foreach (vecs[i]) begin
      v = vecs[i];
      run($sformatf("vec%0d", i), v.we, v.sz, v.uns, v.addr, v.wdata, 1'b1, v.rd, v.er, v.lat);
    end

    // Randomized traffic against the byte-level model
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [1:0]  s;
      t1 = $urandom_range(0, 19);
      if (t1 == 0)      a = $urandom;
      else if (t1 == 1) a = $urandom_range(32'h100, 32'h10F);
      else              a = $urandom_range(0, 255);
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
          a, $urandom, 1'b0, 32'h0, 1'b0, 0);
    end

    // Reset during RMW_WR: write abandoned, no response
    preload(2, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h9; req_wdata = 32'hAA;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmwrst.rd_phase", {31'd0, MemRead}, 32'd1);
    @(negedge clk);
    chk("rmwrst.wr_phase", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmwrst.memwr_drop", {31'd0, MemWrite}, 32'd0);
    chk("rmwrst.no_rsp0", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rmwrst.no_rsp1", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rmwrst.ready", {31'd0, req_ready}, 32'd1);
    nrsp = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) nrsp++; end
    chk("rmwrst.no_rsp_after", 32'(nrsp), 32'd0);
    chk("rmwrst.mem_word", mem[2], 32'h55667788);
    run("rmwrst.reload", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1, 32'h55667788, 1'b0, 2);

    // Back-to-back loads with req_valid held high
    ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_a, etmp, t1, t2, t3);
    ref_op(1'b0, 2'd0, 1'b0, 32'h02, 32'h0, e_b, etmp, t1, t2, t3);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_size = 2'd0; req_addr = 32'h02;
    acc2 = -1; nrsp = 0; busy_hi = 0; r1 = '0; r2 = '0; rk[0] = -1; rk[1] = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (acc2 >= 0 && k == acc2 + 1) req_valid = 1'b0;
      if (rsp_valid) begin
        if (nrsp < 2) rk[nrsp] = k;
        if (nrsp == 0) r1 = rsp_rdata; else r2 = rsp_rdata;
        nrsp++;
      end
      if (req_ready && req_valid && acc2 < 0) acc2 = k;
      if ((k == 1 || k == 2 || k == 4 || k == 5) && req_ready) busy_hi++;
    end
    req_valid = 1'b0;
    k1 = rk[0];
    chk("b2b.nrsp", 32'(nrsp), 32'd2);
    chk("b2b.rsp1_cycle", 32'(k1), 32'd2);
    chk("b2b.rsp1_data", r1, e_a);
    chk("b2b.accept2", 32'(acc2), 32'(k1 + 1));
    chk("b2b.rsp2_cycle", 32'(rk[1]), 32'd5);
    chk("b2b.rsp2_data", r2, e_b);
    chk("b2b.ready_low", 32'(busy_hi), 32'd0);

    rtmp = '0; er = 1'b0; rd = '0; maddr = '0; mwd = '0; lat = 0; nrd = 0; nwr = 0; bad = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
